truth_table_scanner: RTL and testbench

//   Sequential front/back end for an N-input combinational subsystem under analysis.

---
 rtl/truth_table_scanner_if.sv | 45 ++++
 rtl/truth_table_scanner.sv | 126 ++++++++++++
 tb/tb_truth_table_scanner.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_if.sv
// -----------------------------------------------------------------------------
// truth_table_scanner_if
//   Bundles the request/result signals of truth_table_scanner. Signal prefixes
//   are relative to the scanner: i_* flow into it, o_* flow out of it.
//
//   Handshake: i_start is a level request that the scanner samples only while
//   idle. An accepted start raises o_busy at the same edge. o_busy stays high
//   for the whole scan. o_done pulses for exactly one cycle when the result is
//   complete. o_valid then stays high, with o_table/o_ones frozen, until the
//   next accepted start. A start seen while o_busy=1 is ignored.
//
//   Ports (scanner view, modport slave):
//     i_start    in   1      request a full scan
//     i_f_in     in   1      output of the subsystem under analysis
//     o_vars     out  N      input combination driven to the subsystem
//     o_busy     out  1      scan in progress
//     o_done     out  1      one-cycle completion pulse
//     o_valid    out  1      o_table/o_ones hold a complete result
//     o_table    out  2^N    o_table[i] = i_f_in sampled while o_vars == i
//     o_ones     out  N+1    population count of o_table
//     o_dbg_scan out  1      FSM state (1 = SCAN, 0 = IDLE)
// -----------------------------------------------------------------------------
interface truth_table_scanner_if #(
  parameter int N = 3
);
  logic                 i_start;
  logic                 i_f_in;
  logic [N-1:0]         o_vars;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_valid;
  logic [(1<<N)-1:0]    o_table;
  logic [N:0]           o_ones;
  logic                 o_dbg_scan;

  modport slave (
    input  i_start, i_f_in,
    output o_vars, o_busy, o_done, o_valid, o_table, o_ones, o_dbg_scan
  );

  modport master (
    output i_start, i_f_in,
    input  o_vars, o_busy, o_done, o_valid, o_table, o_ones, o_dbg_scan
  );
endinterface

// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//   Walks an N-input combinational block through every input combination
//   0..2^N-1. Each combination is held for SETTLE cycles, and the block output
//   is sampled on the last edge of that interval. The samples are assembled
//   into a 2^N-bit truth table and counted.
//   All outputs are registered, so there is no combinational path from
//   i_start or i_f_in to any output.
//
//   Parameters:
//     N       number of inputs of the block under analysis (1..6)
//     SETTLE  cycles each combination is held before sampling (>= 1)
//
//   Ports:
//     clk     in   rising-edge clock
//     reset   in   asynchronous, active-low reset; aborts any scan
//     bus     truth_table_scanner_if.slave (see interface header)
// -----------------------------------------------------------------------------
module truth_table_scanner #(
  parameter int N      = 3,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  truth_table_scanner_if.slave    bus
);

  localparam int              CW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int              TW         = 1 << N;
  localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE - 1);
  localparam logic [N-1:0]    VARS_LAST  = {N{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [N-1:0]     r_vars,  w_vars_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic             r_valid, w_valid_nxt;
  logic [TW-1:0]    r_table, w_table_nxt;
  logic [N:0]       r_ones,  w_ones_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vars  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_table <= '0;
      r_ones  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vars  <= w_vars_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
      r_table <= w_table_nxt;
      r_ones  <= w_ones_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vars_nxt  = r_vars;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;          // done is a single-cycle pulse
    w_valid_nxt = r_valid;
    w_table_nxt = r_table;
    w_ones_nxt  = r_ones;

    case (r_state)
      ST_IDLE: begin
        // Accepting start also covers the done cycle, which is why start
        // held high produces back-to-back scans with one idle cycle between.
        if (bus.i_start) begin
          w_vars_nxt  = '0;
          w_cnt_nxt   = CNT_RELOAD;
          w_table_nxt = '0;
          w_ones_nxt  = '0;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          // Sample edge: the subsystem has seen r_vars for SETTLE cycles.
          w_table_nxt[r_vars] = bus.i_f_in;
          w_ones_nxt          = r_ones + {{N{1'b0}}, bus.i_f_in};
          if (r_vars == VARS_LAST) begin
            w_vars_nxt  = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_vars_nxt = r_vars + N'(1);
            w_cnt_nxt  = CNT_RELOAD;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.o_vars     = r_vars;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_valid    = r_valid;
  assign bus.o_table    = r_table;
  assign bus.o_ones     = r_ones;
  assign bus.o_dbg_scan = (r_state == ST_SCAN);

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_scanner_if #(.N(3)) ifa ();
  truth_table_scanner_if #(.N(3)) ifb ();

  truth_table_scanner #(.N(3), .SETTLE(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  truth_table_scanner #(.N(3), .SETTLE(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  // Function modes for the modelled subsystem on DUT A:
  // 0: f = vars[0], 1: f = 1, 2: f = 0, 3: f = parity(vars)
  int fmode;

  function automatic logic f_of(input int mode, input logic [2:0] v);
    case (mode)
      0:       return v[0];
      1:       return 1'b1;
      2:       return 1'b0;
      default: return ^v;
    endcase
  endfunction

  always_comb ifa.i_f_in = f_of(fmode, ifa.o_vars);
  always_comb ifb.i_f_in = ^ifb.o_vars;

  // ---------------------------------------------------------------- scoreboard
  // Entry = {ones[3:0], table[7:0]}
  logic [11:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [11:0] model(input int mode);
    logic [7:0] t;
    logic [3:0] n;
    logic [2:0] v;
    t = '0;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      v    = 3'(i);
      t[i] = f_of(mode, v);
      n    = n + {3'b000, t[i]};
    end
    return {n, t};
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset       = 1'b0;
    ifa.i_start = 1'b0;
    ifb.i_start = 1'b0;
    fmode       = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.o_vars, ifa.o_busy, ifa.o_done, ifa.o_valid, ifa.o_table, ifa.o_ones, ifa.o_dbg_scan} !== '0) begin
      errors++;
      $display("FAIL reset_a: got vars=%0d busy=%b done=%b valid=%b table=%h ones=%0d, want all 0",
               ifa.o_vars, ifa.o_busy, ifa.o_done, ifa.o_valid, ifa.o_table, ifa.o_ones);
    end
    checks++;
    if ({ifb.o_vars, ifb.o_busy, ifb.o_done, ifb.o_valid, ifb.o_table, ifb.o_ones, ifb.o_dbg_scan} !== '0) begin
      errors++;
      $display("FAIL reset_b: got vars=%0d busy=%b valid=%b table=%h ones=%0d, want all 0",
               ifb.o_vars, ifb.o_busy, ifb.o_valid, ifb.o_table, ifb.o_ones);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One scan on DUT A. cyc counts negedges after the edge that takes start,
  // so the final sample edge (16 edges later) is visible at cyc 17.
  task automatic run_scan_a(input int mode, input bit check_vars, input bit repulse, input string name);
    logic [11:0] exp;
    int          cyc;
    bit          seen;
    fmode = mode;
    exp_q.push_back(model(mode));
    ifa.i_start = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) ifa.i_start = 1'b0;
      if (repulse && (cyc == 3 || cyc == 9))  ifa.i_start = 1'b1;
      if (repulse && (cyc == 4 || cyc == 10)) ifa.i_start = 1'b0;
      if (ifa.o_done) begin
        seen = 1'b1;
      end else if (check_vars && cyc <= 16) begin
        checks++;
        if (ifa.o_vars !== 3'((cyc - 1) / 2) || ifa.o_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_vars_seq: cyc %0d got vars=%0d busy=%b, want vars=%0d busy=1",
                   name, cyc, ifa.o_vars, ifa.o_busy, (cyc - 1) / 2);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles, want done at 17", name, cyc);
      ifa.i_start = 1'b0;
      return;
    end
    if (cyc != 17) begin
      errors++;
      $display("FAIL %s_latency: done at cycle %0d, want 17", name, cyc);
    end
    exp = exp_q.pop_front();
    checks++;
    if (ifa.o_table !== exp[7:0] || ifa.o_ones !== exp[11:8]) begin
      errors++;
      $display("FAIL %s_result: got table=%b ones=%0d, want table=%b ones=%0d",
               name, ifa.o_table, ifa.o_ones, exp[7:0], exp[11:8]);
    end
    checks++;
    if (ifa.o_valid !== 1'b1 || ifa.o_vars !== 3'd0 || ifa.o_busy !== 1'b0 || ifa.o_dbg_scan !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: got valid=%b vars=%0d busy=%b scan=%b, want 1 0 0 0",
               name, ifa.o_valid, ifa.o_vars, ifa.o_busy, ifa.o_dbg_scan);
    end
    @(negedge clk);
    checks++;
    if (ifa.o_done !== 1'b0 || ifa.o_valid !== 1'b1 || ifa.o_table !== exp[7:0]) begin
      errors++;
      $display("FAIL %s_after_done: got done=%b valid=%b table=%b, want done=0 valid=1 table=%b",
               name, ifa.o_done, ifa.o_valid, ifa.o_table, exp[7:0]);
    end
  endtask

  task automatic test_basic();
    run_scan_a(0, 1'b0, 1'b0, "t1_lsb");
  endtask

  task automatic test_constants();
    run_scan_a(1, 1'b0, 1'b0, "t2_ones");
    run_scan_a(2, 1'b0, 1'b0, "t2_zeros");
  endtask

  task automatic test_parity_sequence();
    run_scan_a(3, 1'b1, 1'b0, "t3_parity");
  endtask

  task automatic test_start_while_busy();
    run_scan_a(0, 1'b0, 1'b1, "t4_repulse");
  endtask

  task automatic test_async_reset();
    int cyc;
    fmode = 3;
    exp_q.push_back(model(3));
    ifa.i_start = 1'b1;
    @(negedge clk);
    ifa.i_start = 1'b0;
    cyc = 0;
    while (ifa.o_vars !== 3'd5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ifa.o_vars !== 3'd5) begin
      errors++;
      $display("FAIL t5_reach_vars5: got vars=%0d after %0d cycles, want 5", ifa.o_vars, cyc);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ifa.o_vars, ifa.o_busy, ifa.o_done, ifa.o_valid, ifa.o_table, ifa.o_ones, ifa.o_dbg_scan} !== '0) begin
      errors++;
      $display("FAIL t5_async_clear: got vars=%0d busy=%b valid=%b table=%b ones=%0d, want all 0",
               ifa.o_vars, ifa.o_busy, ifa.o_valid, ifa.o_table, ifa.o_ones);
    end
    exp_q.delete();  // aborted scan leaves no result
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_scan_a(3, 1'b0, 1'b0, "t5_rescan");
  endtask

  // DUT B, SETTLE=1, start held high: done every 9 cycles, first at cyc 9.
  task automatic test_back_to_back();
    logic [11:0] exp;
    int          cyc;
    int          prev;
    int          ndone;
    bit          chk_restart;
    exp_q.push_back(model(3));
    ifb.i_start = 1'b1;
    cyc = 0; prev = 0; ndone = 0; chk_restart = 1'b0;
    while (ndone < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ifb.o_done) begin
        exp = exp_q.pop_front();
        checks++;
        if (ifb.o_table !== exp[7:0] || ifb.o_ones !== exp[11:8] || ifb.o_valid !== 1'b1) begin
          errors++;
          $display("FAIL t6_result%0d: got table=%b ones=%0d valid=%b, want table=%b ones=%0d valid=1",
                   ndone, ifb.o_table, ifb.o_ones, ifb.o_valid, exp[7:0], exp[11:8]);
        end
        checks++;
        if (cyc - prev != 9) begin
          errors++;
          $display("FAIL t6_period%0d: done %0d cycles after previous, want 9", ndone, cyc - prev);
        end
        prev = cyc;
        ndone++;
        if (ndone < 3) begin
          exp_q.push_back(model(3));
          chk_restart = 1'b1;
        end else begin
          ifb.i_start = 1'b0;
        end
      end else if (chk_restart) begin
        chk_restart = 1'b0;
        checks++;
        if (ifb.o_valid !== 1'b0 || ifb.o_busy !== 1'b1) begin
          errors++;
          $display("FAIL t6_restart: got valid=%b busy=%b after restart, want valid=0 busy=1",
                   ifb.o_valid, ifb.o_busy);
        end
      end
    end
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL t6_timeout: got %0d done pulses in %0d cycles, want 3", ndone, cyc);
    end
    @(negedge clk);
    checks++;
    if (ifb.o_busy !== 1'b0 || ifb.o_valid !== 1'b1 || ifb.o_done !== 1'b0) begin
      errors++;
      $display("FAIL t6_stop: got busy=%b valid=%b done=%b, want 0 1 0",
               ifb.o_busy, ifb.o_valid, ifb.o_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_basic();
    test_constants();
    test_parity_sequence();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
